// File: rtl/alu_seq_n.sv
// Registered N-bit ALU with a start/done handshake, status flags and a
// multi-cycle unsigned shift-add multiplier. Single-cycle ops complete on the
// accepting edge. MUL holds busy_o high for N cycles, one step per edge.
module alu_seq_n #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [N-1:0] A_i,
    input  logic [N-1:0] B_i,
    input  logic         c_i,
    input  logic [3:0]   ope_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] sal_o,
    output logic [N-1:0] sal_hi_o,
    output logic         c_o,
    output logic         ovf_o,
    output logic         zero_o,
    output logic         neg_o,
    output logic         ill_o
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Multiplier working registers: multiplicand, accumulator (high half)
    // and the multiplier that shifts out as product bits shift in (low half).
    logic [N-1:0]     mcand_reg;
    logic [N-1:0]     hi_reg;
    logic [N-1:0]     lo_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Bitwise logic results, one slice per bit.
    logic [N-1:0] and_bits;
    logic [N-1:0] or_bits;
    logic [N-1:0] xor_bits;
    logic [N-1:0] nor_bits;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_logic
            assign and_bits[gi] = A_i[gi] & B_i[gi];
            assign or_bits[gi]  = A_i[gi] | B_i[gi];
            assign xor_bits[gi] = A_i[gi] ^ B_i[gi];
            assign nor_bits[gi] = ~(A_i[gi] | B_i[gi]);
        end
    endgenerate

    // Adder/subtractor with carry out; SUB uses A + ~B + 1.
    logic [N:0] add_sum;
    logic [N:0] sub_sum;
    logic       add_ovf;
    logic       sub_ovf;

    assign add_sum = {1'b0, A_i} + {1'b0, B_i} + {{N{1'b0}}, c_i};
    assign sub_sum = {1'b0, A_i} + {1'b0, ~B_i} + {{N{1'b0}}, 1'b1};
    assign add_ovf = (A_i[N-1] == B_i[N-1])  && (add_sum[N-1] != A_i[N-1]);
    assign sub_ovf = (A_i[N-1] == ~B_i[N-1]) && (sub_sum[N-1] != A_i[N-1]);

    // One shift-add step: conditionally add the multiplicand into the high
    // half, then shift the whole {carry, hi, lo} right by one.
    logic [N:0]   mul_sum;
    logic [N-1:0] mul_hi_next;
    logic [N-1:0] mul_lo_next;

    assign mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : {(N+1){1'b0}});
    assign mul_hi_next = mul_sum[N:1];
    assign mul_lo_next = {mul_sum[0], lo_reg[N-1:1]};

    assign busy_o = (state_reg == S_MUL);
    assign done_o = (state_reg == S_DONE);

    // Result and flags of a single-cycle op, computed from the live inputs.
    logic [N-1:0] op_sal;
    logic         op_c;
    logic         op_ovf;
    logic         op_ill;

    // Select the single-cycle result for the presented opcode.
    always_comb begin
        op_sal = '0;
        op_c   = 1'b0;
        op_ovf = 1'b0;
        op_ill = 1'b0;
        case (ope_i)
            OP_AND: op_sal = and_bits;
            OP_OR:  op_sal = or_bits;
            OP_XOR: op_sal = xor_bits;
            OP_NOR: op_sal = nor_bits;
            OP_ADD: begin
                op_sal = add_sum[N-1:0];
                op_c   = add_sum[N];
                op_ovf = add_ovf;
            end
            OP_SUB: begin
                op_sal = sub_sum[N-1:0];
                op_c   = sub_sum[N];
                op_ovf = sub_ovf;
            end
            OP_SLT: begin
                // Sign of the difference, corrected when the subtraction overflowed.
                op_sal = {{(N-1){1'b0}}, sub_sum[N-1] ^ sub_ovf};
                op_c   = sub_sum[N];
                op_ovf = sub_ovf;
            end
            default: op_ill = 1'b1;
        endcase
    end

    // Next-state logic: accept in IDLE/DONE, step through MUL otherwise.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_MUL: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = S_DONE;
                end
            end
            default: begin
                if (start_i) begin
                    state_next = (ope_i == OP_MUL) ? S_MUL : S_DONE;
                end else begin
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    // State register; reset aborts any multiply in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath: multiplier steps and registered result/flags. Outputs change
    // only when an op completes, so they hold between done pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcand_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            cnt_reg   <= '0;
            sal_o     <= '0;
            sal_hi_o  <= '0;
            c_o       <= 1'b0;
            ovf_o     <= 1'b0;
            zero_o    <= 1'b0;
            neg_o     <= 1'b0;
            ill_o     <= 1'b0;
        end else begin
            case (state_reg)
                S_MUL: begin
                    hi_reg <= mul_hi_next;
                    lo_reg <= mul_lo_next;
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg  <= '0;
                        sal_o    <= mul_lo_next;
                        sal_hi_o <= mul_hi_next;
                        c_o      <= |mul_hi_next;
                        ovf_o    <= 1'b0;
                        zero_o   <= (mul_hi_next == '0) && (mul_lo_next == '0);
                        neg_o    <= mul_hi_next[N-1];
                        ill_o    <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (start_i) begin
                        if (ope_i == OP_MUL) begin
                            mcand_reg <= A_i;
                            hi_reg    <= '0;
                            lo_reg    <= B_i;
                            cnt_reg   <= '0;
                        end else begin
                            sal_o    <= op_sal;
                            sal_hi_o <= '0;
                            c_o      <= op_c;
                            ovf_o    <= op_ovf;
                            zero_o   <= (op_sal == '0);
                            neg_o    <= op_sal[N-1];
                            ill_o    <= op_ill;
                        end
                    end
                end
            endcase
        end
    end

endmodule
